vec_stage_sequencer: RTL

- Sequences one chunked vector stage (e.g. Bias) sitting between an input VecFIFO and an output VecFIFO.
- Tracks how many whole vectors the input FIFO holds and how much whole-vector space the output FIFO has.
- Asserts the stage's in_data_ready only when one full vector can be read and one full vector can be written.
- Counts the stage's chunk requests, retires vectors, and flags protocol, overflow and timeout errors.

---
 rtl/vec_seq_pkg.sv | 16 +
 rtl/credit_counter.sv | 37 +++
 rtl/vec_stage_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/vec_seq_pkg.sv
// Shared types and helpers for the vector stage sequencer.
// Holds the FSM state encoding, the error flag bit positions and the chunk count helper.
package vec_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} seq_state_t;

  localparam int ErrInOvf   = 0;
  localparam int ErrOutUnf  = 1;
  localparam int ErrProto   = 2;
  localparam int ErrTimeout = 3;

  function automatic int chunks_per_vec(input int vec_elements, input int bytes_per_chunk);
    return vec_elements / bytes_per_chunk;
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Saturating credit counter with a small signed step per cycle.
// Same-cycle increments and decrements net against each other before the saturation check.
module credit_counter #(
  parameter int Max      = 2,
  parameter int ResetVal = 0,
  parameter int W        = $clog2(Max + 1)
) (
  input  logic         clk_sys,
  input  logic         rst_b,
  input  logic [1:0]   inc,
  input  logic [1:0]   dec,
  output logic [W-1:0] count,
  output logic         overflow,
  output logic         underflow
);

  int sum;

  always_comb begin
    sum       = int'(count) + int'(inc) - int'(dec);
    overflow  = (sum > Max);
    underflow = (sum < 0);
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_b) begin
      count <= W'(ResetVal);
    end else if (overflow) begin
      count <= W'(Max);
    end else if (underflow) begin
      count <= '0;
    end else begin
      count <= W'(sum);
    end
  end

endmodule

// File: rtl/vec_stage_sequencer.sv
// Sequences one chunked vector stage between an input and an output vector FIFO.
// state | meaning
// IDLE  | waiting for a whole input vector, a free output slot and en_in
// RUN   | stage reads and writes the vector's chunks
// DRAIN | all chunks moved, waiting for the stage's vector valid
module vec_stage_sequencer import vec_seq_pkg::*; #(
  parameter int VecElements    = 8,
  parameter int BytesPerChunk  = 4,
  parameter int InDepth        = 2,
  parameter int OutDepth       = 2,
  parameter int WatchdogCycles = 256
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          en_in,
  input  logic                          in_wr_vec_done,
  input  logic                          out_rd_vec_done,
  input  logic                          stage_req_chunk_in,
  input  logic                          stage_req_chunk_out,
  input  logic                          stage_vec_valid,
  output logic                          stage_data_ready,
  output logic [$clog2(InDepth+1)-1:0]  in_vecs_avail,
  output logic [$clog2(OutDepth+1)-1:0] out_space_avail,
  output logic                          busy,
  output logic [15:0]                   vecs_done,
  output logic [3:0]                    err_flags
);

  localparam int ChunksPerVec = chunks_per_vec(VecElements, BytesPerChunk);
  localparam int CntW = $clog2(ChunksPerVec + 1);
  localparam int WdW  = $clog2(WatchdogCycles + 1);
  localparam logic [CntW-1:0] CpvCnt = CntW'(ChunksPerVec);
  localparam logic [WdW-1:0]  WdLoad = WdW'(WatchdogCycles - 1);

  seq_state_t      state;
  logic [CntW-1:0] rd_cnt, wr_cnt, rd_nxt, wr_nxt;
  logic [WdW-1:0]  wd_cnt;
  logic            start, rd_ok, wr_ok, rd_last, retire, timeout, to_drain;
  logic            in_ovf, in_unf, out_ovf, out_unf;
  logic [3:0]      err_set;

  always_comb begin
    start    = (state == IDLE) && en_in && (in_vecs_avail != '0) && (out_space_avail != '0);
    rd_ok    = (state == RUN) && stage_req_chunk_in && (rd_cnt != CpvCnt);
    wr_ok    = (state == RUN) && stage_req_chunk_out && (wr_cnt != CpvCnt);
    rd_nxt   = rd_cnt + CntW'(rd_ok);
    wr_nxt   = wr_cnt + CntW'(wr_ok);
    rd_last  = rd_ok && (rd_nxt == CpvCnt);
    retire   = (state == DRAIN) && stage_vec_valid;
    // A vector that completes on the watchdog's last cycle still counts as retired.
    timeout  = (state != IDLE) && (wd_cnt == '0) && !retire;
    to_drain = (state == RUN) && (rd_nxt == CpvCnt) && (wr_nxt == CpvCnt);

    err_set             = '0;
    err_set[ErrInOvf]   = in_ovf | in_unf;
    err_set[ErrOutUnf]  = out_ovf | out_unf;
    err_set[ErrProto]   = (stage_req_chunk_in && !rd_ok) || (stage_req_chunk_out && !wr_ok) ||
                          (stage_vec_valid && (state != DRAIN));
    err_set[ErrTimeout] = timeout;
  end

  credit_counter #(.Max(InDepth), .ResetVal(0)) u_in_credits (
    .clk_sys   (clk_in),
    .rst_b     (rst_in),
    .inc       ({1'b0, in_wr_vec_done}),
    .dec       ({1'b0, rd_last}),
    .count     (in_vecs_avail),
    .overflow  (in_ovf),
    .underflow (in_unf)
  );

  // A timed-out vector hands its reserved output slot back.
  credit_counter #(.Max(OutDepth), .ResetVal(OutDepth)) u_out_credits (
    .clk_sys   (clk_in),
    .rst_b     (rst_in),
    .inc       ({1'b0, out_rd_vec_done} + {1'b0, timeout}),
    .dec       ({1'b0, start}),
    .count     (out_space_avail),
    .overflow  (out_ovf),
    .underflow (out_unf)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state            <= IDLE;
      stage_data_ready <= 1'b0;
      rd_cnt           <= '0;
      wr_cnt           <= '0;
      wd_cnt           <= '0;
      busy             <= 1'b0;
      vecs_done        <= '0;
      err_flags        <= '0;
    end else begin
      err_flags <= err_flags | err_set;
      if (state == IDLE) begin
        stage_data_ready <= 1'b0;
        if (start) begin
          state  <= RUN;
          busy   <= 1'b1;
          rd_cnt <= '0;
          wr_cnt <= '0;
          wd_cnt <= WdLoad;
        end
      end else if (timeout) begin
        state            <= IDLE;
        busy             <= 1'b0;
        stage_data_ready <= 1'b0;
      end else if (retire) begin
        state     <= IDLE;
        busy      <= 1'b0;
        vecs_done <= vecs_done + 16'd1;
      end else begin
        wd_cnt           <= wd_cnt - WdW'(1);
        rd_cnt           <= rd_nxt;
        wr_cnt           <= wr_nxt;
        stage_data_ready <= (state == RUN) && (rd_nxt != CpvCnt);
        if (to_drain) state <= DRAIN;
      end
    end
  end

endmodule
